rr_sel_scheduler: RTL and testbench

- Round-robin scheduler that drives the 3-bit select of the downstream six-way 4-bit data multiplexer.
- Six sources raise request lines. The block grants one source at a time for a burst of up to MAX_BURST beats, then rotates priority.
- Emits a registered select, a one-hot grant and a valid qualifier, and honours downstream backpressure.
- Select never leaves 0..5, so the mux default (all-zero) output is unreachable in normal operation.

---
 rtl/rr_sched_pkg.sv | 31 +++
 rtl/rr_pick.sv | 29 ++
 rtl/rr_sel_scheduler.sv | 92 +++++++++
 tb/tb_rr_sel_scheduler.sv | 123 ++++++++++++
 4 files changed

// File: rtl/rr_sched_pkg.sv
// Shared constants, FSM state type and pointer helpers for the round-robin
// select scheduler that drives the six-way mux select.
package rr_sched_pkg;

    localparam int NUM_SRC       = 6;
    localparam int SEL_W         = 3;
    localparam int DEF_MAX_BURST = 4;
    localparam int DEF_CNT_W     = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // p + off modulo NUM_SRC; off is always below NUM_SRC so one fold suffices
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= NUM_SRC) s = s - NUM_SRC;
        return SEL_W'(s);
    endfunction

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] p);
        return wrap_add(p, 1);
    endfunction

    function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder: first unmasked request scanning
// from ptr upward with wrap at NUM_SRC-1.
module rr_pick
    import rr_sched_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    input  logic [NUM_SRC-1:0] mask,
    output logic               any,
    output logic [SEL_W-1:0]   winner
);

    logic [NUM_SRC-1:0] cand;

    assign cand = req & ~mask;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        // scan farthest offset first so the candidate nearest ptr is written last
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[wrap_add(ptr, i)]) begin
                any    = 1'b1;
                winner = wrap_add(ptr, i);
            end
        end
    end

endmodule

// File: rtl/rr_sel_scheduler.sv
// Burst round-robin scheduler: registers mux select and one-hot grant,
// qualifies beats with out_valid and honours out_ready backpressure.
module rr_sel_scheduler
    import rr_sched_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               areset_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_SRC-1:0] grant,
    output logic               out_valid,
    output logic               beat_done
);

    state_t             state;
    logic [SEL_W-1:0]   ptr;
    logic [CNT_W-1:0]   beat_cnt;

    logic               in_grant;
    logic               transfer;
    logic               last_beat;
    logic               abandon;
    logic               burst_end;
    logic [SEL_W-1:0]   arb_ptr;
    logic [NUM_SRC-1:0] arb_mask;
    logic               arb_any;
    logic [SEL_W-1:0]   arb_win;

    assign in_grant  = (state == GRANT);
    assign out_valid = in_grant && req[sel];
    assign transfer  = out_valid && out_ready;
    assign beat_done = transfer;
    assign last_beat = transfer && (beat_cnt == CNT_W'(MAX_BURST - 1));
    assign abandon   = in_grant && !req[sel];
    assign burst_end = last_beat || abandon;

    // Ending a burst re-arbitrates in the same cycle from sel+1 with the
    // just-served source masked, so back-to-back bursts have no bubble.
    assign arb_ptr  = in_grant ? wrap_inc(sel) : ptr;
    assign arb_mask = in_grant ? onehot(sel) : '0;

    rr_pick u_pick (
        .req    (req),
        .ptr    (arb_ptr),
        .mask   (arb_mask),
        .any    (arb_any),
        .winner (arb_win)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state    <= IDLE;
            sel      <= '0;
            grant    <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        state    <= GRANT;
                        sel      <= arb_win;
                        grant    <= onehot(arb_win);
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (burst_end) begin
                        ptr      <= arb_ptr;
                        beat_cnt <= '0;
                        if (arb_any) begin
                            sel   <= arb_win;
                            grant <= onehot(arb_win);
                        end else begin
                            // sel is left alone so the mux output stays stable while idle
                            state <= IDLE;
                            grant <= '0;
                        end
                    end else if (transfer) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_sel_scheduler.sv
// Directed cycle-by-cycle checks of select/grant/valid/beat_done against
// hand-derived schedules for the default MAX_BURST=4 configuration.
module tb_rr_sel_scheduler;

    logic       clk = 1'b0;
    logic       areset_n = 1'b0;
    logic [5:0] req = '0;
    logic       out_ready = 1'b1;
    logic [2:0] sel;
    logic [5:0] grant;
    logic       out_valid;
    logic       beat_done;

    int n_pass = 0;
    int n_chk  = 0;

    rr_sel_scheduler dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .beat_done (beat_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic expect_out(input string tag, input int es, input int eg, input int ev, input int ed);
        chk({tag, " sel"},       int'(sel),       es);
        chk({tag, " grant"},     int'(grant),     eg);
        chk({tag, " out_valid"}, int'(out_valid), ev);
        chk({tag, " beat_done"}, int'(beat_done), ed);
    endtask

    // one cycle: inputs applied just after the edge, outputs checked 2 time units later
    task automatic cyc(input string tag, input logic [5:0] r, input logic rdy,
                       input int es, input int eg, input int ev, input int ed);
        @(posedge clk);
        #1;
        req       = r;
        out_ready = rdy;
        #1;
        expect_out(tag, es, eg, ev, ed);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        areset_n  = 1'b0;
        req       = '0;
        out_ready = 1'b1;
        #1;
        expect_out(tag, 0, 0, 0, 0);
        #1;
        areset_n = 1'b1;
    endtask

    initial begin
        // T1: single source 2, burst of 4, one idle cycle, re-grant
        do_reset("t1 rst");
        cyc("t1 c0", 6'h04, 1'b1, 0, 0, 0, 0);
        for (int c = 1; c <= 4; c++) cyc($sformatf("t1 c%0d", c), 6'h04, 1'b1, 2, 4, 1, 1);
        cyc("t1 gap", 6'h04, 1'b1, 2, 0, 0, 0);
        cyc("t1 regrant", 6'h04, 1'b1, 2, 4, 1, 1);

        // T2: sources 1 and 2 alternate bursts without bubbles
        do_reset("t2 rst");
        cyc("t2 c0", 6'h06, 1'b1, 0, 0, 0, 0);
        for (int c = 1; c <= 4; c++)  cyc($sformatf("t2 c%0d", c), 6'h06, 1'b1, 1, 2, 1, 1);
        for (int c = 5; c <= 8; c++)  cyc($sformatf("t2 c%0d", c), 6'h06, 1'b1, 2, 4, 1, 1);
        for (int c = 9; c <= 12; c++) cyc($sformatf("t2 c%0d", c), 6'h06, 1'b1, 1, 2, 1, 1);

        // T3: pointer wraps 5 -> 0, then back to 5
        do_reset("t3 rst");
        cyc("t3 c0", 6'h20, 1'b1, 0, 0, 0, 0);
        for (int c = 1; c <= 4; c++) cyc($sformatf("t3 c%0d", c), 6'h21, 1'b1, 5, 32, 1, 1);
        for (int c = 5; c <= 8; c++) cyc($sformatf("t3 c%0d", c), 6'h21, 1'b1, 0, 1, 1, 1);
        cyc("t3 c9", 6'h21, 1'b1, 5, 32, 1, 1);

        // T4: backpressure after beat 2 holds everything, then exactly 2 more beats
        do_reset("t4 rst");
        cyc("t4 c0", 6'h03, 1'b1, 0, 0, 0, 0);
        cyc("t4 c1", 6'h03, 1'b1, 0, 1, 1, 1);
        cyc("t4 c2", 6'h03, 1'b1, 0, 1, 1, 1);
        for (int c = 3; c <= 5; c++) cyc($sformatf("t4 stall%0d", c), 6'h03, 1'b0, 0, 1, 1, 0);
        cyc("t4 c6", 6'h03, 1'b1, 0, 1, 1, 1);
        cyc("t4 c7", 6'h03, 1'b1, 0, 1, 1, 1);
        cyc("t4 c8", 6'h03, 1'b1, 1, 2, 1, 1);

        // T5: source 3 abandons after 2 beats; source 0 takes over next cycle
        do_reset("t5 rst");
        cyc("t5 c0", 6'h08, 1'b1, 0, 0, 0, 0);
        cyc("t5 c1", 6'h09, 1'b1, 3, 8, 1, 1);
        cyc("t5 c2", 6'h09, 1'b1, 3, 8, 1, 1);
        cyc("t5 drop", 6'h01, 1'b1, 3, 8, 0, 0);
        cyc("t5 c4", 6'h01, 1'b1, 0, 1, 1, 1);

        // T6: asynchronous reset mid-burst, then fresh grant to source 4
        do_reset("t6 rst");
        cyc("t6 c0", 6'h02, 1'b1, 0, 0, 0, 0);
        cyc("t6 c1", 6'h02, 1'b1, 1, 2, 1, 1);
        #1;
        areset_n = 1'b0;
        #1;
        expect_out("t6 async", 0, 0, 0, 0);
        #1;
        areset_n = 1'b1;
        req      = 6'h10;
        cyc("t6 after", 6'h10, 1'b1, 4, 16, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
